// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the multi-cycle M-extension
//                sequencer: ALU control codes, FSM state encoding, op-type
//                encoding and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // ALU control codes that the sequencer accepts
    localparam logic [3:0] ALU_MUL = 4'b1011;
    localparam logic [3:0] ALU_DIV = 4'b1100;
    localparam logic [3:0] ALU_REM = 4'b1101;

    // Sequencer FSM states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Operation captured at accept time
    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_REM = 2'd2
    } op_t;

    // True for the three control codes the sequencer services
    function automatic logic is_muldiv_code(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REM);
    endfunction

    // Map an accepted control code onto the internal op type
    function automatic op_t decode_op(input logic [3:0] code);
        op_t op;
        case (code)
            ALU_DIV: op = OP_DIV;
            ALU_REM: op = OP_REM;
            default: op = OP_MUL;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational iteration of unsigned restoring division.
//                Shifts the next dividend bit (quotient MSB) into the partial
//                remainder, trial-subtracts the divisor and restores when the
//                difference goes negative. The new quotient bit enters at the
//                LSB as the dividend bits leave at the MSB.
//  Revision    : 1.0 - initial release
//
//  Ports
//    rem_in   in  XLEN+1  partial remainder
//    quo_in   in  XLEN    quotient / remaining dividend bits
//    divisor  in  XLEN    divisor magnitude
//    rem_out  out XLEN+1  next partial remainder
//    quo_out  out XLEN    next quotient
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    // Shifted remainder carries one extra MSB so the trial difference has a
    // dedicated sign bit; the partial remainder always stays below the
    // divisor, so that extra bit is zero going in.
    logic [XLEN+1:0] w_shifted;
    logic [XLEN+1:0] w_diff;
    logic            w_restore;

    always_comb begin
        w_shifted = {rem_in, quo_in[XLEN-1]};
        w_diff    = w_shifted - {2'b00, divisor};
        w_restore = w_diff[XLEN+1];
        rem_out   = w_restore ? w_shifted[XLEN:0] : w_diff[XLEN:0];
        quo_out   = {quo_in[XLEN-2:0], ~w_restore};
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle sequencer for mul / div / rem. Accepts one op at
//                a time from execute, stalls the pipeline while iterating
//                (shift-add multiply or restoring division, one bit per
//                cycle), applies sign correction and returns a registered
//                result with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
//
//  Configuration macro
//    MULDIV_FAST_MUL_EN  defined   : mul uses one combinational XLEN x XLEN
//                                    multiply and skips the MUL state.
//                        undefined : iterative shift-add multiply.
//
//  Ports
//    clk          in  1     system clock
//    rst          in  1     asynchronous active-high reset
//    start        in  1     execute stage presents an op this cycle
//    alu_control  in  4     ALU control code (1011 mul, 1100 div, 1101 rem)
//    operand_a    in  XLEN  rs1 (multiplicand / dividend)
//    operand_b    in  XLEN  rs2 (multiplier / divisor)
//    flush        in  1     abort any op in flight
//    stall        out 1     hold fetch/decode/execute
//    busy         out 1     FSM not idle
//    done         out 1     one-cycle result-valid pulse
//    result       out XLEN  product low word / quotient / remainder
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] c_MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(XLEN - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;     // {product high, multiplier / product low}
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN:0]       r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_dvsr;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_fix;
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Accept decode and special-case detection
    // ------------------------------------------------------------------
    logic            w_valid_code;
    logic            w_is_mul;
    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic            w_last_step;

    always_comb begin
        w_valid_code = is_muldiv_code(alu_control);
        w_is_mul     = (alu_control == ALU_MUL);
        // flush wins over a simultaneous accept
        w_accept     = (r_state == IDLE) && start && w_valid_code && !flush;
        w_a_neg      = operand_a[XLEN-1];
        w_b_neg      = operand_b[XLEN-1];
        // Magnitude of the most negative value wraps to itself, which is the
        // correct unsigned magnitude 2^(XLEN-1).
        w_a_mag      = w_a_neg ? (~operand_a + 1'b1) : operand_a;
        w_b_mag      = w_b_neg ? (~operand_b + 1'b1) : operand_b;
        w_div_zero   = (operand_b == '0);
        w_div_ovf    = (operand_a == c_MIN_INT) && (operand_b == '1);
        w_special    = !w_is_mul && (w_div_zero || w_div_ovf);
        w_last_step  = (r_cnt == c_LAST_STEP);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0] w_prod;
    assign w_prod = operand_a * operand_b;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right with
    // the adder carry entering at the top.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_acc_nxt;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                  + (r_acc[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
        w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    end

    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_dvsr),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    // Sign-corrected result selected by the captured op
    logic [XLEN-1:0] w_fix_val;

    always_comb begin
        w_fix_val = '0;
        case (r_op)
            OP_MUL: w_fix_val = r_acc[XLEN-1:0];
            OP_DIV: w_fix_val = r_neg_q ? (~r_quo + 1'b1) : r_quo;
            OP_REM: w_fix_val = r_neg_r ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
            default: w_fix_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // FIXUP spans two cycles (r_cnt 0 then 1): the first registers the
    // sign-corrected value, the second commits it to result, so a flush
    // anywhere in FIXUP leaves result untouched.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                stall = start && w_valid_code;
                if (w_accept) begin
                    if (w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        w_state_nxt = FIXUP;
`else
                        w_state_nxt = MUL;
`endif
                    end else if (w_special) begin
                        w_state_nxt = FIXUP;
                    end else begin
                        w_state_nxt = DIV;
                    end
                end
            end
            MUL: begin
                stall = 1'b1;
                if (w_last_step) w_state_nxt = FIXUP;
            end
            DIV: begin
                stall = 1'b1;
                if (w_last_step) w_state_nxt = FIXUP;
            end
            FIXUP: begin
                stall = 1'b1;
                if (r_cnt != '0) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fix    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= decode_op(alu_control);
                        r_cnt   <= '0;
                        r_mcand <= operand_a;
                        r_acc   <= {{XLEN{1'b0}}, operand_b};
`ifdef MULDIV_FAST_MUL_EN
                        if (w_is_mul) r_acc <= {{XLEN{1'b0}}, w_prod};
`endif
                        r_dvsr  <= w_b_mag;
                        if (w_div_zero) begin
                            // quotient all ones, remainder is the dividend
                            r_quo   <= '1;
                            r_rem   <= {1'b0, operand_a};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_div_ovf) begin
                            // quotient is the dividend, remainder zero
                            r_quo   <= operand_a;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= w_last_step ? '0 : r_cnt + CNT_W'(1);
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= w_last_step ? '0 : r_cnt + CNT_W'(1);
                end
                FIXUP: begin
                    if (r_cnt == '0) begin
                        r_fix <= w_fix_val;
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_result <= r_fix;
                        r_cnt    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer. Expected results
//                are queued when an op is issued and popped when done
//                pulses; latency, stall count, flush and reset behaviour
//                are checked with directed steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_pass  = 0;
    int n_total = 0;
    logic [XLEN-1:0] sb[$];

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model for signed div/rem and low-word multiply
    function automatic logic [31:0] model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (code == ALU_MUL) r = a * b;
        else if (b == 32'd0) r = (code == ALU_DIV) ? 32'hFFFF_FFFF : a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = (code == ALU_DIV) ? a : 32'd0;
        else if (code == ALU_DIV) r = $signed(a) / $signed(b);
        else r = $signed(a) % $signed(b);
        return r;
    endfunction

    // Issue one op at a negedge, scramble operands after accept, wait for
    // done (bounded), then compare latency, stall count and result.
    // inject >= 0 pulses a stray start for one cycle at that cycle index.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int exp_stall, input int inject);
        int lat;
        int nstall;
        logic [31:0] e;
        sb.push_back(exp);
        start = 1'b1; alu_control = code; operand_a = a; operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        lat = 0; nstall = 0;
        @(negedge clk);
        while (!done && lat < 200) begin
            start = 1'b0;
            if (stall) nstall++;
            if (lat == inject) begin
                start = 1'b1; alu_control = ALU_MUL;
                operand_a = 32'd9; operand_b = 32'd9;
            end
            @(posedge clk); lat++; @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " stall cycles"}, nstall, exp_stall);
        check({tag, " stall in done"}, {31'd0, stall}, 32'd0);
        e = sb.pop_front();
        check({tag, " result"}, result, e);
        @(posedge clk); @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
        check({tag, " result held"}, result, e);
    endtask

    initial begin
        int ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;
        rst = 1'b1; start = 1'b0; alu_control = 4'd0;
        operand_a = '0; operand_b = '0; flush = 1'b0;

        // Reset state
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Iterative ops
        run_op("mul 7*-3", ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 34, -1);
        run_op("div -20/3", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 34, -1);
        run_op("rem -20/3", ALU_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 34, -1);

        // Special cases
        run_op("div 5/0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 2, -1);
        run_op("rem 5/0", ALU_REM, 32'd5, 32'd0, 32'd5, 2, 2, -1);
        run_op("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 2, -1);
        run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 2, -1);

        // Unsupported code: no stall, no state change
        start = 1'b1; alu_control = 4'b0010; operand_a = 32'd1; operand_b = 32'd2;
        #1;
        check("bad code stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("bad code busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);

        // Stray start during DIV is ignored
        run_op("div 100/7 w/ stray start", ALU_DIV, 32'd100, 32'd7, 32'd14, 34, 34, 5);

        // Flush on the 10th cycle of a mul; result keeps 14
        start = 1'b1; alu_control = ALU_MUL; operand_a = 32'd3; operand_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush stall", {31'd0, stall}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush no done", ndone, 0);
        check("flush result held", result, 32'd14);
        run_op("mul after flush", ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0,
               model(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0), 34, 34, -1);

        // Pseudo-random ops against the model
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k[0]) rb = {{20{rb[31]}}, rb[11:0]};
            case (k % 3)
                0: rc = ALU_MUL;
                1: rc = ALU_DIV;
                default: rc = ALU_REM;
            endcase
            run_op("random op", rc, ra, rb, model(rc, ra, rb),
                   (rb == 0 && rc != ALU_MUL) ? 2 : 34, (rb == 0 && rc != ALU_MUL) ? 2 : 34, -1);
        end

        // Asynchronous reset mid-DIV
        start = 1'b1; alu_control = ALU_DIV; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst stall", {31'd0, stall}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("div after rst", ALU_DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 34, 34, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
